bcd2bin_seq: RTL and testbench

Parametrised sequential BCD-to-binary converter: accepts a DIGITS-digit packed BCD word over a valid/ready handshake, converts it by iterative right-shift with subtract-3 correction (one bit per cycle), and presents the binary result on a held output handshake. It is the multi-digit, back-pressure-capable successor to the two-digit converter in the longsegment example datapath. It sits between BCD-producing front ends (keypad/display logic) and binary arithmetic consumers.

---
 rtl/bcd2bin_pkg.sv | 33 +++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd2bin_seq.sv | 128 ++++++++++++
 tb/tb_bcd2bin_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared types and elaboration-time helpers for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest n such that 2**n >= value.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned     n;
    longint unsigned p;
    n = 0;
    p = 1;
    while (p < value) begin
      p = p << 1;
      n++;
    end
    return n;
  endfunction

  // Bits needed to hold any value below 10**digits.
  function automatic int unsigned pow10_bits(input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return clog2(p);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for right-shift BCD-to-binary conversion: digit >= 8 loses 3.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Subtract-3 correction; inputs >= 8 never underflow.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd8) begin
      digit_out = digit_in - 4'd3;
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential DIGITS-digit BCD-to-binary converter, one result bit per cycle,
// valid/ready on input and a held valid/ready result on output.
// Optional macro BCD2BIN_ERR_CHECK_EN: reject words holding a digit > 9 (err=1, bin=0).
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter  int unsigned DIGITS = 4,
  localparam int unsigned BIN_W  = pow10_bits(DIGITS),
  localparam int unsigned CNT_W  = clog2(longint'(BIN_W) + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_shift, bcd_adj;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic               bad_digit;

  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_shift[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  // Flag any input digit outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  // Next-state, datapath and registered-handshake computation.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          err_d = bad_digit;
          bin_d = '0;
          if (bad_digit) begin
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            bcd_d   = bcd_in;
            cnt_d   = CNT_W'(BIN_W);
            state_d = OP;
          end
        end
      end
      OP: begin
        bin_d = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_d = bcd_adj;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs follow the next state so they are registered, not decoded.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and handshake registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin       = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed, scoreboard-checked bench for bcd2bin_seq (DIGITS = 4, 1 and 9).
module tb_bcd2bin_seq;

  localparam int unsigned W4 = 14;
  localparam int unsigned W1 = 4;
  localparam int unsigned W9 = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic          in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0]   bcd_in;
  logic [W4-1:0] bin;

  logic          in_valid1, in_ready1, out_valid1, out_ready1, err1;
  logic [3:0]    bcd_in1;
  logic [W1-1:0] bin1;

  logic          in_valid9, in_ready9, out_valid9, out_ready9, err9;
  logic [35:0]   bcd_in9;
  logic [W9-1:0] bin9;

  bcd2bin_seq #(.DIGITS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready), .bin(bin), .err(err)
  );

  bcd2bin_seq #(.DIGITS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .bcd_in(bcd_in1), .out_valid(out_valid1), .out_ready(out_ready1), .bin(bin1), .err(err1)
  );

  bcd2bin_seq #(.DIGITS(9)) u_dut9 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid9), .in_ready(in_ready9),
    .bcd_in(bcd_in9), .out_valid(out_valid9), .out_ready(out_ready9), .bin(bin9), .err(err9)
  );

  typedef struct {
    logic [W4-1:0] bin;
    logic          err;
    int unsigned   lat;
    bit            chk_bin;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned prev_acc = 0;
  int unsigned acc_cnt = 0;
  int unsigned cur_lat = 0;
  logic        ov_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sampled mid-cycle, sees the values that apply at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && in_valid && in_ready) begin
      prev_acc = acc_cyc;
      acc_cyc  = cyc + 1;
      acc_cnt++;
    end
    if (reset_n && out_valid && !ov_prev) begin
      cur_lat = cyc - acc_cyc + 1;
    end
    if (reset_n && out_valid && out_ready) begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_bin) check("res_bin", 64'(bin), 64'(mon_e.bin));
        check("res_err", 64'(err), 64'(mon_e.err));
        check("res_lat", 64'(cur_lat), 64'(mon_e.lat));
      end
    end
    ov_prev = reset_n && out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int unsigned g;
    g = 0;
    in_valid = 1'b1;
    bcd_in   = w;
    while (!in_ready && g < 100) begin
      step();
      g++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 300) begin
      step();
      g++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int unsigned g;
    int unsigned n;
    int unsigned lat;

    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; bcd_in1 = '0;
    in_valid9 = 1'b0; out_ready9 = 1'b1; bcd_in9 = '0;
    repeat (3) step();
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bin",       64'(bin),       64'd0);
    check("rst_err",       64'(err),       64'd0);
    reset_n = 1'b1;
    step();

    // Single conversion, consumer always ready.
    out_ready = 1'b1;
    exp_q.push_back('{14'd1234, 1'b0, 15, 1'b1});
    send(16'h1234);
    drain();

    // Back-to-back words: second accepted in IDLE, 16-cycle period.
    exp_q.push_back('{14'd9999, 1'b0, 15, 1'b1});
    exp_q.push_back('{14'd0, 1'b0, 15, 1'b1});
    send(16'h9999);
    send(16'h0000);
    check("b2b_period", 64'(acc_cyc - prev_acc), 64'd16);
    drain();

    // Back-pressure: result held, pending word waits for the handshake.
    out_ready = 1'b0;
    exp_q.push_back('{14'd42, 1'b0, 15, 1'b1});
    send(16'h0042);
    g = 0;
    while (!out_valid && g < 100) begin
      step();
      g++;
    end
    check("hold_valid_seen", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    bcd_in   = 16'h0011;
    n = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_bin",       64'(bin),       64'd42);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_no_accept", 64'(acc_cnt),   64'(n));
    end
    exp_q.push_back('{14'd11, 1'b0, 15, 1'b1});
    out_ready = 1'b1;
    step();
    check("done_no_accept", 64'(acc_cnt),   64'(n));
    check("idle_in_ready",  64'(in_ready),  64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    step();
    check("idle_accept",    64'(acc_cnt),   64'(n + 1));
    in_valid = 1'b0;
    drain();

    // Illegal digit handling.
`ifdef BCD2BIN_ERR_CHECK_EN
    exp_q.push_back('{14'd0, 1'b1, 1, 1'b1});
`else
    exp_q.push_back('{14'd0, 1'b0, 15, 1'b0});
`endif
    send(16'h12A4);
    drain();
    exp_q.push_back('{14'd7, 1'b0, 15, 1'b1});
    send(16'h0007);
    drain();

    // Reset during OP iteration 6 discards the conversion.
    send(16'h5678);
    repeat (5) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_bin",       64'(bin),       64'd0);
    check("abort_err",       64'(err),       64'd0);
    exp_q.push_back('{14'd5678, 1'b0, 15, 1'b1});
    send(16'h5678);
    drain();

    // Width extremes: one digit and nine digits.
    check("d1_ready", 64'(in_ready1), 64'd1);
    in_valid1 = 1'b1;
    bcd_in1   = 4'h9;
    step();
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 100) begin
      step();
      lat++;
    end
    check("d1_lat", 64'(lat),  64'd5);
    check("d1_bin", 64'(bin1), 64'd9);
    check("d1_err", 64'(err1), 64'd0);

    check("d9_ready", 64'(in_ready9), 64'd1);
    in_valid9 = 1'b1;
    bcd_in9   = 36'h999999999;
    step();
    in_valid9 = 1'b0;
    lat = 1;
    while (!out_valid9 && lat < 100) begin
      step();
      lat++;
    end
    check("d9_lat", 64'(lat),  64'd31);
    check("d9_bin", 64'(bin9), 64'd999999999);
    check("d9_err", 64'(err9), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
